// File: rtl/gpr_readout_pkg.sv
// Shared processor definitions: IR field layout, opcodes, GPR geometry,
// readback tag encoding and the readback engine state encoding.
// Imported by the readback engine and its stream interface.
package gpr_readout_pkg;

  // GPR file geometry
  localparam int GPR_NUM    = 32;
  localparam int GPR_DATA_W = 16;
  localparam int GPR_IDX_W  = 5;
  localparam int GPR_CNT_W  = GPR_IDX_W + 1;
  localparam int GPR_TAG_W  = GPR_IDX_W + 1;

  // Tag carried by the SGPR word: MSB set, index field zero
  localparam logic [GPR_TAG_W-1:0] SGPR_TAG = 6'b100000;

  // Instruction register field positions
  localparam int IR_OPER_TYPE_MSB = 31;
  localparam int IR_OPER_TYPE_LSB = 27;
  localparam int IR_RDST_MSB      = 26;
  localparam int IR_RDST_LSB      = 22;
  localparam int IR_RSRC1_MSB     = 21;
  localparam int IR_RSRC1_LSB     = 17;
  localparam int IR_IMM_MODE      = 16;
  localparam int IR_RSRC2_MSB     = 15;
  localparam int IR_RSRC2_LSB     = 11;
  localparam int IR_ISRC_MSB      = 15;
  localparam int IR_ISRC_LSB      = 0;

  // Opcodes
  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_ROR     = 5'd5;
  localparam logic [4:0] OP_RAND    = 5'd6;
  localparam logic [4:0] OP_RXOR    = 5'd7;
  localparam logic [4:0] OP_RXNOR   = 5'd8;
  localparam logic [4:0] OP_RNAND   = 5'd9;
  localparam logic [4:0] OP_RNOR    = 5'd10;
  localparam logic [4:0] OP_RNOT    = 5'd11;

  // Readback engine states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_SGPR  = 3'd3,
    ST_OUT   = 3'd4,
    ST_FIN   = 3'd5
  } rd_state_e;

endpackage

// File: rtl/gpr_readout_if.sv
// Readback word stream: data, {is_sgpr, idx} tag, last marker.
// No latency of its own; plain wires between producer and sink.
// Valid/ready: the producer holds a word stable until valid && ready.
interface gpr_readout_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6
);
  logic [DATA_W-1:0] dout_data;
  logic [TAG_W-1:0]  dout_tag;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output dout_data, dout_tag, dout_valid, dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout_data, dout_tag, dout_valid, dout_last,
    output dout_ready
  );
endinterface

// File: rtl/gpr_readout.sv
// Register-file readback: streams a GPR window (wrapping at 31) and optionally SGPR.
// Latency: start -> rf_re 1 cycle, -> first word valid 3 cycles; 3 cycles/word at full rate.
// Backpressure: word held stable in OUT until dout_ready; abort drops it immediately.
module gpr_readout
  import gpr_readout_pkg::*;
#(
  parameter int NUM_GPR = GPR_NUM,
  parameter int DATA_W  = GPR_DATA_W
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic [GPR_IDX_W-1:0] start_idx,
  input  logic [GPR_CNT_W-1:0] count,
  input  logic                 include_sgpr,
  input  logic                 abort,
  output logic                 rf_re,
  output logic [GPR_IDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  input  logic [DATA_W-1:0]    sgpr_in,
  output logic                 busy,
  output logic                 done,
  gpr_readout_if.master        dout_if
);

  rd_state_e              r_state;
  rd_state_e              w_state_nxt;
  logic [GPR_IDX_W-1:0]   r_cur_idx;
  logic [GPR_CNT_W-1:0]   r_remaining;
  logic                   r_incl_sgpr;
  logic                   r_sgpr_sent;
  logic [DATA_W-1:0]      r_dout_data;
  logic [GPR_TAG_W-1:0]   r_dout_tag;
  logic                   r_dout_valid;
  logic                   r_dout_last;

  logic                   w_accept;
  logic                   w_hs;
  logic                   w_word_is_sgpr;
  logic [GPR_CNT_W-1:0]   w_count_clamped;
  logic [GPR_CNT_W-1:0]   w_remaining_after;

  // A window never exceeds the register file, so the wrap cannot revisit an entry
  assign w_count_clamped = (count > GPR_CNT_W'(NUM_GPR)) ? GPR_CNT_W'(NUM_GPR) : count;
  // start is only honoured in IDLE and loses to a simultaneous abort
  assign w_accept        = (r_state == ST_IDLE) && start && !abort;
  assign w_hs            = r_dout_valid && dout_if.dout_ready;
  assign w_word_is_sgpr  = r_dout_tag[GPR_TAG_W-1];
  // The SGPR word does not consume a GPR slot
  assign w_remaining_after = w_word_is_sgpr ? r_remaining : (r_remaining - GPR_CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection; abort overrides everything including a handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_count_clamped != '0) begin
            w_state_nxt = ST_ISSUE;
          end else if (include_sgpr) begin
            w_state_nxt = ST_SGPR;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_ISSUE: w_state_nxt = ST_CAPT;
      ST_CAPT:  w_state_nxt = ST_OUT;
      ST_SGPR:  w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (w_hs) begin
          if (w_remaining_after != '0) begin
            w_state_nxt = ST_ISSUE;
          end else if (r_incl_sgpr && !r_sgpr_sent) begin
            w_state_nxt = ST_SGPR;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Command context and output word register
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cur_idx    <= '0;
      r_remaining  <= '0;
      r_incl_sgpr  <= 1'b0;
      r_sgpr_sent  <= 1'b0;
      r_dout_data  <= '0;
      r_dout_tag   <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cur_idx   <= start_idx;
            r_remaining <= w_count_clamped;
            r_incl_sgpr <= include_sgpr;
            r_sgpr_sent <= 1'b0;
          end
        end
        ST_CAPT: begin
          r_dout_data  <= rf_rdata;
          r_dout_tag   <= {1'b0, r_cur_idx};
          r_dout_valid <= 1'b1;
          r_dout_last  <= (r_remaining == GPR_CNT_W'(1)) && !r_incl_sgpr;
        end
        ST_SGPR: begin
          // SGPR is sampled here rather than at start so it reflects the latest multiply
          r_dout_data  <= sgpr_in;
          r_dout_tag   <= SGPR_TAG;
          r_dout_valid <= 1'b1;
          r_dout_last  <= 1'b1;
          r_sgpr_sent  <= 1'b1;
        end
        ST_OUT: begin
          if (w_hs) begin
            r_dout_valid <= 1'b0;
            if (!w_word_is_sgpr) begin
              r_remaining <= w_remaining_after;
              r_cur_idx   <= r_cur_idx + GPR_IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (abort) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign rf_re    = (r_state == ST_ISSUE);
  assign rf_raddr = r_cur_idx;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_FIN);

  assign dout_if.dout_data  = r_dout_data;
  assign dout_if.dout_tag   = r_dout_tag;
  assign dout_if.dout_valid = r_dout_valid;
  assign dout_if.dout_last  = r_dout_last;

endmodule

// File: tb/tb_gpr_readout.sv
// Bench for gpr_readout: randomized windows checked against a list-based reference.
// Inputs driven 1 time unit after the rising edge; outputs observed on the falling edge.
// The sink's ready is driven by the bench to create stalls.
module tb_gpr_readout;
  import gpr_readout_pkg::*;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  start_idx = '0;
  logic [5:0]  count = '0;
  logic        include_sgpr = 1'b0;
  logic        abort = 1'b0;
  logic        rf_re;
  logic [4:0]  rf_raddr;
  logic [15:0] rf_rdata = '0;
  logic [15:0] sgpr_in = '0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  gpr_readout_if #(.DATA_W(16), .TAG_W(6)) dif ();

  gpr_readout #(.NUM_GPR(32), .DATA_W(16)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .start_idx    (start_idx),
    .count        (count),
    .include_sgpr (include_sgpr),
    .abort        (abort),
    .rf_re        (rf_re),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .sgpr_in      (sgpr_in),
    .busy         (busy),
    .done         (done),
    .dout_if      (dif.master)
  );

  // Register file with one-cycle read latency
  logic [15:0] gpr [32];
  always @(posedge clk) begin
    if (rf_re) rf_rdata <= gpr[rf_raddr];
  end

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed stream and event bookkeeping; word = {last, tag[5:0], data[15:0]}
  logic [22:0] obs_q[$];
  logic [22:0] exp_q[$];
  int rf_cnt = 0, done_cnt = 0, first_v = -1, first_re = -1, last_hs = -1, done_cyc = -1;
  int stall_bad = 0;
  logic prev_stall = 1'b0;
  logic [22:0] prev_word = '0;

  always @(negedge clk) begin
    if (prev_stall && (dif.dout_valid !== 1'b1 ||
        {dif.dout_last, dif.dout_tag, dif.dout_data} !== prev_word))
      stall_bad++;
    prev_stall = dif.dout_valid && !dif.dout_ready;
    prev_word  = {dif.dout_last, dif.dout_tag, dif.dout_data};
    if (dif.dout_valid && first_v < 0) first_v = cyc;
    if (dif.dout_valid && dif.dout_ready) begin
      obs_q.push_back({dif.dout_last, dif.dout_tag, dif.dout_data});
      last_hs = cyc;
    end
    if (rf_re) begin
      rf_cnt++;
      if (first_re < 0) first_re = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    rf_cnt = 0; done_cnt = 0; first_v = -1; first_re = -1;
    last_hs = -1; done_cyc = -1; stall_bad = 0;
  endtask

  // Issue one command and check the whole stream; entered and left at posedge+1
  task automatic do_cmd(input string nm, input logic [4:0] sidx, input logic [5:0] cnt,
                        input logic inc, input int stall_word);
    int n, idx, start_cyc, t;
    logic stalled;
    n = (cnt > 6'd32) ? 32 : int'(cnt);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      idx = (int'(sidx) + i) % 32;
      exp_q.push_back({((i == n - 1) && !inc), 1'b0, 5'(idx), gpr[idx]});
    end
    if (inc) exp_q.push_back({1'b1, SGPR_TAG, sgpr_in});
    clear_obs();
    stalled = 1'b0;
    start_idx = sidx; count = cnt; include_sgpr = inc; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk_eq({nm, "_busy_after_start"}, busy, 1);
    t = 0;
    while (done_cnt == 0 && t < 600) begin
      if (stall_word >= 0 && !stalled && obs_q.size() == stall_word && dif.dout_valid) begin
        dif.dout_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dif.dout_ready = 1'b1;
        stalled = 1'b1;
        t += 5;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk_eq({nm, "_done_seen"}, done_cnt > 0, 1);
    chk_eq({nm, "_busy_cleared"}, busy, 0);
    @(posedge clk); #1;
    chk_eq({nm, "_done_pulses"}, done_cnt, 1);
    chk_eq({nm, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk_eq($sformatf("%s_word%0d", nm, i), obs_q[i], exp_q[i]);
    chk_eq({nm, "_rf_re_count"}, rf_cnt, n);
    if (n > 0) begin
      chk_eq({nm, "_lat_rf_re"}, first_re - start_cyc, 1);
      chk_eq({nm, "_lat_valid"}, first_v - start_cyc, 3);
    end
    if (exp_q.size() > 0) chk_eq({nm, "_done_after_last"}, done_cyc - last_hs, 1);
    else chk_eq({nm, "_no_valid"}, first_v, -1);
    if (stall_word >= 0 && stall_word < exp_q.size()) begin
      chk_eq({nm, "_stall_hit"}, stalled, 1);
      chk_eq({nm, "_stall_stable"}, stall_bad, 0);
    end
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 32; i++) gpr[i] = 16'($urandom);
    sgpr_in = 16'($urandom);
  endtask

  initial begin
    int t;
    dif.dout_ready = 1'b1;
    for (int i = 0; i < 32; i++) gpr[i] = 16'(3 * i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_valid", dif.dout_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_rf_re", rf_re, 0);
    chk_eq("rst_word", {dif.dout_last, dif.dout_tag, dif.dout_data}, 0);
    sys_rst = 1'b0;
    @(posedge clk); #1;

    // Basic window: words 6,9,12,15 tags 2..5
    do_cmd("basic", 5'd2, 6'd4, 1'b0, -1);

    // Wrap plus SGPR
    sgpr_in = 16'h00A5;
    do_cmd("wrap", 5'd30, 6'd4, 1'b1, -1);

    // Backpressure on the second word
    do_cmd("stall", 5'd9, 6'd4, 1'b0, 1);

    // Empty windows
    do_cmd("cnt0", 5'd4, 6'd0, 1'b0, -1);
    sgpr_in = 16'h1234;
    do_cmd("cnt0sgpr", 5'd4, 6'd0, 1'b1, -1);

    // Oversized count is clamped to the full file
    rand_regs();
    do_cmd("cnt40", 5'd17, 6'd40, 1'b1, 3);

    // start and abort together in IDLE: start is dropped
    clear_obs();
    start_idx = 5'd1; count = 6'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk_eq("start_abort_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_eq("start_abort_no_re", rf_cnt, 0);

    // Abort mid-stream, with an ignored start during word 1
    rand_regs();
    clear_obs();
    start_idx = 5'd5; count = 6'd6; include_sgpr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!dif.dout_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk_eq("abort_w1_valid", dif.dout_valid, 1);
    start = 1'b1; start_idx = 5'd17; count = 6'd1;
    @(posedge clk); #1;
    start = 1'b0;
    dif.dout_ready = 1'b0;
    t = 0;
    while (!dif.dout_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk_eq("abort_w2_valid", dif.dout_valid, 1);
    chk_eq("abort_w2_tag", dif.dout_tag, 6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_eq("abort_valid_drop", dif.dout_valid, 0);
    chk_eq("abort_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_eq("abort_no_done", done_cnt, 0);
    chk_eq("abort_nwords", obs_q.size(), 1);
    if (obs_q.size() > 0) chk_eq("abort_word0", obs_q[0], {1'b0, 6'd5, gpr[5]});
    chk_eq("abort_rf_re", rf_cnt, 2);
    dif.dout_ready = 1'b1;
    do_cmd("post_abort", 5'd20, 6'd2, 1'b0, -1);

    // Reset mid-stream while a word is being held
    clear_obs();
    start_idx = 5'd7; count = 6'd5; include_sgpr = 1'b1; start = 1'b1;
    dif.dout_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!dif.dout_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk_eq("mrst_valid_before", dif.dout_valid, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk_eq("mrst_valid", dif.dout_valid, 0);
    chk_eq("mrst_busy", busy, 0);
    chk_eq("mrst_word", {dif.dout_last, dif.dout_tag, dif.dout_data}, 0);
    chk_eq("mrst_raddr", rf_raddr, 0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    dif.dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("mrst_no_done", done_cnt, 0);
    do_cmd("post_rst", 5'd0, 6'd3, 1'b0, -1);

    // Randomized commands
    for (int k = 0; k < 10; k++) begin
      rand_regs();
      do_cmd($sformatf("rnd%0d", k), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 40)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 4)) - 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
